// File: rtl/univ_shift_reg_if.sv
// Control and data bundle for the universal shift register.
// The master drives the operation request; the slave returns the register state.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             en;
    logic [2:0]       mode;
    logic             sin;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic [CW-1:0]    cnt;
    logic             done;

    modport master (
        output en, mode, sin, din,
        input  q, sout, cnt, done
    );

    modport slave (
        input  en, mode, sin, din,
        output q, sout, cnt, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: load, clear, logical/arithmetic shifts
// and rotates in both directions, with registered serial out and saturating shift count.
module univ_shift_reg #(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input logic            clk,
    input logic            rst,
    univ_shift_reg_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] RESET_Q = RESET_VAL[WIDTH-1:0];
    localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_CLR  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             isShift;

    always_comb begin
        q_d     = q_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        isShift = 1'b0;
        if (bus.en) begin
            case (mode_e'(bus.mode))
                MODE_HOLD: ;
                MODE_LOAD: begin
                    q_d    = bus.din;
                    sout_d = 1'b0;
                    cnt_d  = '0;
                end
                MODE_SHL: begin
                    q_d     = {q_q[WIDTH-2:0], bus.sin};
                    sout_d  = q_q[WIDTH-1];
                    isShift = 1'b1;
                end
                MODE_SHR: begin
                    q_d     = {bus.sin, q_q[WIDTH-1:1]};
                    sout_d  = q_q[0];
                    isShift = 1'b1;
                end
                MODE_ROL: begin
                    q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_d  = q_q[WIDTH-1];
                    isShift = 1'b1;
                end
                MODE_ROR: begin
                    q_d     = {q_q[0], q_q[WIDTH-1:1]};
                    sout_d  = q_q[0];
                    isShift = 1'b1;
                end
                MODE_ASR: begin
                    q_d     = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    sout_d  = q_q[0];
                    isShift = 1'b1;
                end
                MODE_CLR: begin
                    q_d    = '0;
                    sout_d = 1'b0;
                    cnt_d  = '0;
                end
                default: ;
            endcase
        end
        // The count stops at WIDTH so done stays asserted until the next LOAD/CLR.
        if (isShift && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= RESET_Q;
            sout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.sout = sout_q;
    assign bus.cnt  = cnt_q;
    assign bus.done = (cnt_q == CNT_MAX);
endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5): directed
// vector table, hand-written reset sequences, and randomized traffic against a model.
module tb_univ_shift_reg;
    localparam int W = 8;

    localparam logic [2:0] HOLD = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] SHL  = 3'd2;
    localparam logic [2:0] SHR  = 3'd3;
    localparam logic [2:0] ROL  = 3'd4;
    localparam logic [2:0] ROR  = 3'd5;
    localparam logic [2:0] ASR  = 3'd6;
    localparam logic [2:0] CLR  = 3'd7;

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic       sin;
        logic [7:0] din;
        logic [7:0] expQ;
        logic       expSout;
        logic [3:0] expCnt;
        logic       expDone;
    } vec_t;

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;

    int   mQ;
    int   mSout;
    int   mCnt;

    vec_t vecs[$];

    univ_shift_reg_if #(.WIDTH(W)) bus ();

    univ_shift_reg #(
        .WIDTH    (W),
        .RESET_VAL(32'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic en, logic [2:0] mode, logic sin, logic [7:0] din,
                                logic [7:0] q, logic s, logic [3:0] c, logic d);
        vec_t v;
        v.en = en; v.mode = mode; v.sin = sin; v.din = din;
        v.expQ = q; v.expSout = s; v.expCnt = c; v.expDone = d;
        return v;
    endfunction

    // Drive one request, let one rising edge consume it, then settle 1 time unit past the edge.
    task automatic applyStimulus(input logic en, input logic [2:0] mode,
                                 input logic sin, input logic [7:0] din);
        bus.en   = en;
        bus.mode = mode;
        bus.sin  = sin;
        bus.din  = din;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expQ,
                               input logic expSout, input logic [3:0] expCnt,
                               input logic expDone);
        assertCount += 4;
        if (bus.q !== expQ) begin
            failCount++;
            $display("[TB] FAIL %s q: got %h expected %h", name, bus.q, expQ);
        end
        if (bus.sout !== expSout) begin
            failCount++;
            $display("[TB] FAIL %s sout: got %b expected %b", name, bus.sout, expSout);
        end
        if (bus.cnt !== expCnt) begin
            failCount++;
            $display("[TB] FAIL %s cnt: got %0d expected %0d", name, bus.cnt, expCnt);
        end
        if (bus.done !== expDone) begin
            failCount++;
            $display("[TB] FAIL %s done: got %b expected %b", name, bus.done, expDone);
        end
    endtask

    // Reference behaviour in plain integer arithmetic on an 8-bit value.
    task automatic modelStep(input logic en, input logic [2:0] mode,
                             input logic sin, input logic [7:0] din);
        int shifted;
        shifted = 0;
        if (en) begin
            case (mode)
                LOAD: begin mQ = din; mSout = 0; mCnt = 0; end
                SHL: begin
                    mSout = (mQ >> 7) & 1;
                    mQ = ((mQ * 2) + sin) % 256;
                    shifted = 1;
                end
                SHR: begin
                    mSout = mQ % 2;
                    mQ = (mQ / 2) + (sin ? 128 : 0);
                    shifted = 1;
                end
                ROL: begin
                    mSout = mQ / 128;
                    mQ = ((mQ * 2) % 256) + (mQ / 128);
                    shifted = 1;
                end
                ROR: begin
                    mSout = mQ % 2;
                    mQ = (mQ / 2) + ((mQ % 2) * 128);
                    shifted = 1;
                end
                ASR: begin
                    mSout = mQ % 2;
                    mQ = (mQ / 2) + ((mQ >= 128) ? 128 : 0);
                    shifted = 1;
                end
                CLR: begin mQ = 0; mSout = 0; mCnt = 0; end
                default: ;
            endcase
        end
        if (shifted != 0 && mCnt < W) mCnt++;
    endtask

    initial begin
        logic       rEn, rSin;
        logic [2:0] rMode;
        logic [7:0] rDin;
        logic [7:0] shlPattern;

        assertCount = 0;
        failCount   = 0;
        bus.en = 1'b0; bus.mode = HOLD; bus.sin = 1'b0; bus.din = 8'h00;

        rst = 1'b1;
        #12;
        rst = 1'b0;
        #2;
        applyStimulus(1'b1, LOAD, 1'b0, 8'h5A);
        applyStimulus(1'b1, SHL, 1'b1, 8'h00);
        checkOutput("preReset", 8'hB5, 1'b0, 4'd1, 1'b0);

        // Reset asserted between edges must take effect with no clock.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncReset", 8'hA5, 1'b0, 4'd0, 1'b0);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, HOLD, 1'b1, 8'hFF);
            checkOutput($sformatf("holdAfterReset%0d", i), 8'hA5, 1'b0, 4'd0, 1'b0);
        end

        vecs.push_back(mk(1, LOAD, 0, 8'h81, 8'h81, 0, 0, 0));
        vecs.push_back(mk(1, ROL,  0, 8'h00, 8'h03, 1, 1, 0));
        vecs.push_back(mk(1, ROR,  0, 8'h00, 8'h81, 1, 2, 0));
        vecs.push_back(mk(1, LOAD, 0, 8'h00, 8'h00, 0, 0, 0));
        shlPattern = 8'b1011_0010;
        begin
            logic [7:0] expQ;
            expQ = 8'h00;
            for (int i = 0; i < 8; i++) begin
                expQ = {expQ[6:0], shlPattern[7-i]};
                vecs.push_back(mk(1, SHL, shlPattern[7-i], 8'h00, expQ, 0, 4'(i + 1), i == 7));
            end
        end
        vecs.push_back(mk(1, SHL,  1, 8'h00, 8'h65, 1, 8, 1));
        vecs.push_back(mk(1, ROR,  0, 8'h00, 8'hB2, 1, 8, 1));
        vecs.push_back(mk(1, LOAD, 0, 8'h90, 8'h90, 0, 0, 0));
        vecs.push_back(mk(1, ASR,  1, 8'h00, 8'hC8, 0, 1, 0));
        vecs.push_back(mk(1, ASR,  1, 8'h00, 8'hE4, 0, 2, 0));
        vecs.push_back(mk(1, SHR,  0, 8'h00, 8'h72, 0, 3, 0));
        vecs.push_back(mk(1, HOLD, 1, 8'hFF, 8'h72, 0, 3, 0));
        vecs.push_back(mk(1, SHR,  1, 8'h00, 8'hB9, 0, 4, 0));
        vecs.push_back(mk(1, LOAD, 0, 8'h3C, 8'h3C, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(0, SHL, 1, 8'hFF, 8'h3C, 0, 0, 0));
        end
        vecs.push_back(mk(1, CLR,  0, 8'hFF, 8'h00, 0, 0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].en, vecs[i].mode, vecs[i].sin, vecs[i].din);
            checkOutput($sformatf("vec%0d", i), vecs[i].expQ, vecs[i].expSout,
                        vecs[i].expCnt, vecs[i].expDone);
        end

        applyStimulus(1'b1, LOAD, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, SHL, 1'b1, 8'h00);
        end
        checkOutput("fiveShifts", 8'h1F, 1'b0, 4'd5, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midShiftReset", 8'hA5, 1'b0, 4'd0, 1'b0);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, LOAD, 1'b0, 8'h0F);
        checkOutput("loadAfterReset", 8'h0F, 1'b0, 4'd0, 1'b0);

        mQ = 8'h0F; mSout = 0; mCnt = 0;
        for (int i = 0; i < 400; i++) begin
            rEn   = ($urandom_range(0, 3) != 0);
            rMode = 3'($urandom_range(0, 7));
            if (rMode == LOAD || rMode == CLR) rMode = ($urandom_range(0, 2) == 0) ? rMode : SHL;
            rSin  = 1'($urandom_range(0, 1));
            rDin  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 59) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                rst = 1'b0;
                mQ = 8'hA5; mSout = 0; mCnt = 0;
            end
            modelStep(rEn, rMode, rSin, rDin);
            applyStimulus(rEn, rMode, rSin, rDin);
            checkOutput($sformatf("rand%0d", i), 8'(mQ), 1'(mSout), 4'(mCnt), mCnt == W);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register.
- Next generation of the single-bit D flip-flop: WIDTH-bit storage, parallel load, and synchronous clear.
- Logical, arithmetic and rotate shifts in both directions, with registered serial I/O and a shift counter.
- Used as the general-purpose register and serialiser/deserialiser primitive in lab datapaths (SPI-style shifters, LED chasers, multiply/divide steppers).

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- RESET_VAL, 0, value of q after reset; WIDTH bits, upper bits ignored.
- CW, $clog2(WIDTH+1), width of cnt; localparam derived from WIDTH, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  operation enable; when 0 all state holds regardless of mode.
- mode  input  3  operation select, sampled on rising clk when en=1.
- sin  input  1  serial input bit for SHL/SHR.
- din  input  WIDTH  parallel load data.
- q  output  WIDTH  registered register contents.
- sout  output  1  registered copy of the bit most recently shifted or rotated out.
- cnt  output  CW  number of shift/rotate operations since the last LOAD/CLR/reset; saturates at WIDTH.
- done  output  1  high while cnt == WIDTH; decoded from the cnt register, no extra latency.

Behaviour:
- Reset: rst=1 asynchronously forces q=RESET_VAL, sout=0, cnt=0, done=0, independent of clk and en.
- Reset mid-operation: the partially shifted value is discarded and the first edge after rst deasserts acts normally.
- All other updates occur on rising clk with en=1. Every operation completes in one cycle and outputs are visible after that edge (latency 1).
- mode 000 HOLD: q, sout, cnt unchanged.
- mode 001 LOAD: q<=din, sout<=0, cnt<=0.
- mode 010 SHL: q<={q[W-2:0],sin}, sout<=q[W-1].
- mode 011 SHR: q<={sin,q[W-1:1]}, sout<=q[0].
- mode 100 ROL: q<={q[W-2:0],q[W-1]}, sout<=q[W-1].
- mode 101 ROR: q<={q[0],q[W-1:1]}, sout<=q[0].
- mode 110 ASR: q<={q[W-1],q[W-1:1]} (sign preserved, sin ignored), sout<=q[0].
- mode 111 CLR: q<=0 (not RESET_VAL), sout<=0, cnt<=0.
- cnt: increments by 1 on each enabled shift/rotate (modes 010..110).
  - Saturates at WIDTH: further shifts still modify q/sout but cnt stays WIDTH.
  - done stays high until LOAD, CLR or reset.
- en=0: mode, sin and din are don't-care; no state changes and cnt does not count.
- X/undefined mode values are not supported; the case statement has a default equal to HOLD.
- q and sout update only via clocked (or async reset) assignment; no combinational path from inputs to q, sout or done.
- Simultaneous events: rst has priority over any clocked operation. LOAD/CLR on the cycle done is high clears done on that edge.

Test Plan:
- WIDTH=8, RESET_VAL=8'hA5. Assert rst mid-cycle with no clk edge -> q=8'hA5, sout=0, cnt=0, done=0 immediately. Release rst, 3 cycles HOLD -> unchanged.
- LOAD din=8'h81, then ROL x1 -> q=8'h03, sout=1, cnt=1. ROR x1 -> q=8'h81, sout=1, cnt=2.
- LOAD 8'h00, then SHL 8 times with sin pattern 1,0,1,1,0,0,1,0 -> q=8'hB2, cnt=8, done=1. A 9th SHL (sin=1) -> q=8'h65, sout=1, cnt stays 8, done=1.
- LOAD 8'h90, then ASR x2 -> q=8'hE4, sout=0. SHR with sin=0 x1 -> q=8'h72, sout=0, cnt=3.
- LOAD 8'h3C, drive mode=SHL with en=0 for 4 cycles -> q=8'h3C, cnt=0. CLR -> q=8'h00, sout=0, cnt=0 (not A5).
- Shift 5 times, pulse rst asynchronously between edges -> q=8'hA5, cnt=0 immediately. Next LOAD 8'h0F on the first edge after release -> q=8'h0F.
